// File: rtl/morse_pkg.sv
// Shared constants for the morse playback engine: symbol codes, FSM encodings,
// default timing units and small helpers.
package morse_pkg;

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b11;

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_FETCH = 4'd1;
   localparam logic [3:0] S_WAIT  = 4'd2;
   localparam logic [3:0] S_LOAD  = 4'd3;
   localparam logic [3:0] S_MARK  = 4'd4;
   localparam logic [3:0] S_SGAP  = 4'd5;
   localparam logic [3:0] S_LGAP  = 4'd6;
   localparam logic [3:0] S_DONE  = 4'd7;

   localparam int unsigned DEF_DOT_UNITS  = 1;
   localparam int unsigned DEF_DASH_UNITS = 3;
   localparam int unsigned DEF_SYM_GAP    = 1;
   localparam int unsigned DEF_LETTER_GAP = 3;

   // Code 10 is not a legal symbol and plays as end-of-letter.
   function automatic logic [1:0] sym_norm(input logic [1:0] p);
      return (p == 2'b10) ? SYM_NONE : p;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/morse_transmitter_if.sv
// Playback port bundle: tick/start control, RAM read port and key outputs.
// Defining MORSE_TX_LOOP_EN adds the loop control input.
interface morse_transmitter_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned WORD_W = 10
);
   logic              tick;
   logic              start;
   logic [ADDR_W:0]   num_words;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [WORD_W-1:0] rd_data;
   logic              key_out;
   logic [1:0]        sym;
   logic              busy;
   logic              done;
`ifdef MORSE_TX_LOOP_EN
   logic              loop;

   modport master (input tick, start, num_words, rd_data, loop,
                   output rd_en, rd_addr, key_out, sym, busy, done);
   modport slave  (output tick, start, num_words, rd_data, loop,
                   input rd_en, rd_addr, key_out, sym, busy, done);
`else
   modport master (input tick, start, num_words, rd_data,
                   output rd_en, rd_addr, key_out, sym, busy, done);
   modport slave  (output tick, start, num_words, rd_data,
                   input rd_en, rd_addr, key_out, sym, busy, done);
`endif
endinterface

// File: rtl/morse_tick_timer.sv
// Loadable down-counter advanced by tick; expire fires on the tick that ends the interval.
module morse_tick_timer #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_cnt;

   // Load wins over decrement so a back-to-back interval starts at full length.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = i_tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/morse_transmitter.sv
// Morse playback engine: fetches letter words from RAM and keys them out as timed marks/spaces.
// Optional MORSE_TX_LOOP_EN repeats playback from address 0 while loop is held.
module morse_transmitter
   import morse_pkg::*;
#(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned WORD_W     = 10,
   parameter int unsigned DOT_UNITS  = DEF_DOT_UNITS,
   parameter int unsigned DASH_UNITS = DEF_DASH_UNITS,
   parameter int unsigned SYM_GAP    = DEF_SYM_GAP,
   parameter int unsigned LETTER_GAP = DEF_LETTER_GAP
) (
   input logic                 clock,
   input logic                 reset,
   morse_transmitter_if.master bus
);

   localparam int unsigned N_SYM = WORD_W / 2;
   localparam int unsigned IDX_W = $clog2(N_SYM + 1);
   localparam int unsigned CNT_W = $clog2(max_u(DASH_UNITS, LETTER_GAP)) + 1;

   logic [3:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_num;
   logic [WORD_W-1:0] r_shift;
   logic [IDX_W-1:0]  r_idx;
   logic              r_key;
   logic [1:0]        r_sym;
   logic              r_rd_en;

   logic [3:0]        w_state_d;
   logic              w_load;
   logic [CNT_W-1:0]  w_load_val;
   logic              w_expire;
   logic [1:0]        w_pair_mark;
   logic [WORD_W-1:0] w_shifted;
   logic [1:0]        w_pair_ld;
   logic [1:0]        w_pair_cur;
   logic [1:0]        w_pair_nx;
   logic [IDX_W-1:0]  w_idx_nx;
   logic              w_last;
   logic              w_loop;

   function automatic logic [CNT_W-1:0] mark_units(input logic [1:0] p);
      return (p == SYM_DASH) ? CNT_W'(DASH_UNITS) : CNT_W'(DOT_UNITS);
   endfunction

   assign w_shifted  = r_shift << 2;
   assign w_pair_ld  = sym_norm(bus.rd_data[WORD_W-1 -: 2]);
   assign w_pair_cur = sym_norm(r_shift[WORD_W-1 -: 2]);
   assign w_pair_nx  = sym_norm(w_shifted[WORD_W-1 -: 2]);
   assign w_idx_nx   = r_idx + 1'b1;
   assign w_last     = ({1'b0, r_addr} == (r_num - 1'b1));
`ifdef MORSE_TX_LOOP_EN
   assign w_loop     = bus.loop;
`else
   assign w_loop     = 1'b0;
`endif

   morse_tick_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .i_tick     (bus.tick),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expire   (w_expire)
   );

   always_comb begin
      w_state_d   = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_pair_mark = SYM_NONE;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_state_d = (bus.num_words != '0) ? S_FETCH : S_DONE;
         S_FETCH: w_state_d = S_WAIT;
         S_WAIT:  w_state_d = S_LOAD;
         S_LOAD: begin
            w_load = 1'b1;
            if (w_pair_ld != SYM_NONE) begin
               w_state_d   = S_MARK;
               w_load_val  = mark_units(w_pair_ld);
               w_pair_mark = w_pair_ld;
            end else begin
               w_state_d  = S_LGAP;
               w_load_val = CNT_W'(LETTER_GAP);
            end
         end
         S_MARK: begin
            if (w_expire) begin
               w_load = 1'b1;
               if ((w_idx_nx == IDX_W'(N_SYM)) || (w_pair_nx == SYM_NONE)) begin
                  w_state_d  = S_LGAP;
                  w_load_val = CNT_W'(LETTER_GAP);
               end else begin
                  w_state_d  = S_SGAP;
                  w_load_val = CNT_W'(SYM_GAP);
               end
            end
         end
         S_SGAP: begin
            if (w_expire) begin
               w_load      = 1'b1;
               w_state_d   = S_MARK;
               w_load_val  = mark_units(w_pair_cur);
               w_pair_mark = w_pair_cur;
            end
         end
         S_LGAP: begin
            if (w_expire) w_state_d = (w_last && !w_loop) ? S_DONE : S_FETCH;
         end
         S_DONE:  w_state_d = S_IDLE;
         default: w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_num   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_key   <= 1'b0;
         r_sym   <= SYM_NONE;
         r_rd_en <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_rd_en <= (w_state_d == S_FETCH);
         r_key   <= (w_state_d == S_MARK);
         // Symbol is captured on MARK entry and held for the whole mark.
         if (w_state_d != S_MARK) begin
            r_sym <= SYM_NONE;
         end else if (r_state != S_MARK) begin
            r_sym <= w_pair_mark;
         end
         if ((r_state == S_IDLE) && bus.start) begin
            r_num  <= bus.num_words;
            r_addr <= '0;
         end
         if (r_state == S_LOAD) begin
            r_shift <= bus.rd_data;
            r_idx   <= '0;
         end
         if ((r_state == S_MARK) && w_expire) begin
            r_shift <= w_shifted;
            r_idx   <= w_idx_nx;
         end
         if ((r_state == S_LGAP) && (w_state_d == S_FETCH)) begin
            r_addr <= w_last ? '0 : r_addr + 1'b1;
         end
      end
   end

   assign bus.rd_en   = r_rd_en;
   assign bus.rd_addr = r_addr;
   assign bus.key_out = r_key;
   assign bus.sym     = r_sym;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = (r_state == S_DONE);

endmodule
